// File: rtl/run_watchdog.sv
// Run-control monitor: cycle limit, per-channel heartbeat supervision and host exit capture,
// folded into one sticky PASS/FAIL verdict with cause and failing channel.
module run_watchdog #(
   parameter int CNT_W = 64,
   parameter int NCH   = 4,
   parameter int TO_W  = 24,
   parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             clear,
   input  logic [CNT_W-1:0] max_cycle,
   input  logic [TO_W-1:0]  hb_timeout,
   input  logic [NCH-1:0]   hb_en,
   input  logic [NCH-1:0]   heartbeat,
   input  logic             exit_valid,
   input  logic [7:0]       exit_code,
   output logic [1:0]       state,
   output logic             done,
   output logic [1:0]       fail_cause,
   output logic [CH_W-1:0]  fail_chan,
   output logic [7:0]       exit_code_q,
   output logic [CNT_W-1:0] cycle_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PASS = 2'd2,
      ST_FAIL = 2'd3
   } state_t;

   localparam logic [1:0]       CAUSE_NONE  = 2'd0;
   localparam logic [1:0]       CAUSE_EXIT  = 2'd1;
   localparam logic [1:0]       CAUSE_LIMIT = 2'd2;
   localparam logic [1:0]       CAUSE_HB    = 2'd3;
   localparam logic [CNT_W-1:0] CNT_ONE     = 1;
   localparam logic [TO_W-1:0]  TO_ONE      = 1;

   state_t            state_reg, state_next;
   logic              done_reg, done_next;
   logic [1:0]        cause_reg, cause_next;
   logic [CH_W-1:0]   chan_reg, chan_next;
   logic [7:0]        code_reg, code_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;

   logic [NCH-1:0]    hb_expire;
   logic              hb_any;
   logic [CH_W-1:0]   hb_first;
   logic              limit_hit;

   // One inactivity counter per channel; each reports a would-be expiry this cycle.
   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_hb
         logic [TO_W-1:0] hb_cnt_reg, hb_cnt_next;
         logic            hb_active;

         assign hb_active     = hb_en[gi] && (hb_timeout != '0);
         assign hb_expire[gi] = hb_active && !heartbeat[gi] &&
                                ((hb_cnt_reg + TO_ONE) == hb_timeout);

         always_comb begin
            hb_cnt_next = hb_cnt_reg;
            if (clear) begin
               hb_cnt_next = '0;
            end else if (state_reg == ST_IDLE) begin
               if (start) hb_cnt_next = '0;
            end else if (state_reg == ST_RUN) begin
               if (!hb_active || heartbeat[gi]) hb_cnt_next = '0;
               else                             hb_cnt_next = hb_cnt_reg + TO_ONE;
            end
         end

         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) hb_cnt_reg <= '0;
            else       hb_cnt_reg <= hb_cnt_next;
         end
      end
   endgenerate

   assign hb_any    = |hb_expire;
   assign limit_hit = (max_cycle != '0) && ((cnt_reg + CNT_ONE) == max_cycle);

   // Descending scan so the lowest-indexed expiring channel wins.
   always_comb begin
      hb_first = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (hb_expire[i]) hb_first = CH_W'(i);
      end
   end

   always_comb begin
      state_next = state_reg;
      cause_next = cause_reg;
      chan_next  = chan_reg;
      code_next  = code_reg;
      cnt_next   = cnt_reg;
      if (clear) begin
         state_next = ST_IDLE;
         cause_next = CAUSE_NONE;
         chan_next  = '0;
         code_next  = '0;
         cnt_next   = '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  state_next = ST_RUN;
                  cnt_next   = '0;
               end
            end
            ST_RUN: begin
               cnt_next = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_ONE;
               if (exit_valid) begin
                  code_next = exit_code;
                  if (exit_code == 8'd0) begin
                     state_next = ST_PASS;
                  end else begin
                     state_next = ST_FAIL;
                     cause_next = CAUSE_EXIT;
                  end
               end else if (limit_hit) begin
                  state_next = ST_FAIL;
                  cause_next = CAUSE_LIMIT;
               end else if (hb_any) begin
                  state_next = ST_FAIL;
                  cause_next = CAUSE_HB;
                  chan_next  = hb_first;
               end
            end
            default: ;
         endcase
      end
      done_next = (state_next == ST_PASS) || (state_next == ST_FAIL);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg <= ST_IDLE;
         done_reg  <= 1'b0;
         cause_reg <= CAUSE_NONE;
         chan_reg  <= '0;
         code_reg  <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         done_reg  <= done_next;
         cause_reg <= cause_next;
         chan_reg  <= chan_next;
         code_reg  <= code_next;
         cnt_reg   <= cnt_next;
      end
   end

   assign state       = state_reg;
   assign done        = done_reg;
   assign fail_cause  = cause_reg;
   assign fail_chan   = chan_reg;
   assign exit_code_q = code_reg;
   assign cycle_cnt   = cnt_reg;

endmodule

// File: tb/tb_run_watchdog.sv
// Bench for run_watchdog: scripted vector table, multi-cycle corner sequences and a
// randomized phase checked against a cycle-level behavioural model.
module tb_run_watchdog;

   localparam int CNT_W = 64;
   localparam int NCH   = 4;
   localparam int TO_W  = 24;
   localparam int CH_W  = 2;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             start = 1'b0;
   logic             clear = 1'b0;
   logic [CNT_W-1:0] max_cycle = '0;
   logic [TO_W-1:0]  hb_timeout = '0;
   logic [NCH-1:0]   hb_en = '0;
   logic [NCH-1:0]   heartbeat = '0;
   logic             exit_valid = 1'b0;
   logic [7:0]       exit_code = '0;
   logic [1:0]       state;
   logic             done;
   logic [1:0]       fail_cause;
   logic [CH_W-1:0]  fail_chan;
   logic [7:0]       exit_code_q;
   logic [CNT_W-1:0] cycle_cnt;

   int tests = 0;
   int fails = 0;

   run_watchdog #(.CNT_W(CNT_W), .NCH(NCH), .TO_W(TO_W), .CH_W(CH_W)) dut (
      .clk(clk), .rstn(rstn), .start(start), .clear(clear),
      .max_cycle(max_cycle), .hb_timeout(hb_timeout), .hb_en(hb_en),
      .heartbeat(heartbeat), .exit_valid(exit_valid), .exit_code(exit_code),
      .state(state), .done(done), .fail_cause(fail_cause), .fail_chan(fail_chan),
      .exit_code_q(exit_code_q), .cycle_cnt(cycle_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   // Verdict mode 0 idle, 1 running, 2 passed, 3 failed; silence[] counts cycles since a
   // channel last showed activity (or was disabled).
   int             m_mode;
   longint unsigned m_cycles;
   int             m_cause;
   int             m_chan;
   int             m_code;
   int unsigned    m_silence[NCH];

   function automatic void model_reset();
      m_mode = 0; m_cycles = 0; m_cause = 0; m_chan = 0; m_code = 0;
      for (int i = 0; i < NCH; i++) m_silence[i] = 0;
   endfunction

   function automatic void model_step();
      bit lim;
      int first;
      if (!rstn || clear) begin
         model_reset();
         return;
      end
      if (m_mode == 0) begin
         if (start) begin
            m_mode = 1; m_cycles = 0;
            for (int i = 0; i < NCH; i++) m_silence[i] = 0;
         end
         return;
      end
      if (m_mode != 1) return;
      lim = (max_cycle != 0) && (m_cycles + 1 == max_cycle);
      first = -1;
      for (int i = 0; i < NCH; i++) begin
         bit watched = hb_en[i] && (hb_timeout != 0);
         if (first < 0 && watched && !heartbeat[i] && (m_silence[i] + 1 == hb_timeout))
            first = i;
      end
      for (int i = 0; i < NCH; i++) begin
         if (hb_en[i] && hb_timeout != 0 && !heartbeat[i]) m_silence[i] = m_silence[i] + 1;
         else                                              m_silence[i] = 0;
      end
      if (m_cycles != 64'hFFFF_FFFF_FFFF_FFFF) m_cycles = m_cycles + 1;
      if (exit_valid) begin
         m_code = exit_code;
         if (exit_code == 0) m_mode = 2;
         else begin m_mode = 3; m_cause = 1; end
      end else if (lim) begin
         m_mode = 3; m_cause = 2;
      end else if (first >= 0) begin
         m_mode = 3; m_cause = 3; m_chan = first;
      end
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".state"}, 64'(state), 64'(m_mode));
      chk({tag, ".done"}, 64'(done), 64'(m_mode >= 2));
      chk({tag, ".cause"}, 64'(fail_cause), 64'(m_cause));
      chk({tag, ".chan"}, 64'(fail_chan), 64'(m_chan));
      chk({tag, ".code"}, 64'(exit_code_q), 64'(m_code));
      chk({tag, ".cnt"}, cycle_cnt, m_cycles);
   endtask

   task automatic restart(input logic [63:0] mc, input logic [23:0] to, input logic [3:0] en);
      max_cycle = mc; hb_timeout = to; hb_en = en; heartbeat = '0; exit_valid = 0;
      clear = 1; step(); clear = 0;
      start = 1; step(); start = 0;
   endtask

   task automatic run_until_verdict(input int bound, output int n);
      n = 0;
      while (state == 2'd1 && n < bound) begin
         step();
         n++;
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        clr;
      logic        st;
      logic        ev;
      logic [7:0]  code;
      logic [1:0]  e_state;
      logic [1:0]  e_cause;
      logic [7:0]  e_code;
      logic [63:0] e_cnt;
   } vec_t;

   vec_t vecs[12];

   initial begin
      int n;
      vecs[0]  = '{1'b0, 1'b0, 1'b1, 8'h05, 2'd0, 2'd0, 8'h00, 64'd0};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 2'd0, 8'h00, 64'd0};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 2'd1, 2'd0, 8'h00, 64'd0};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 2'd1, 2'd0, 8'h00, 64'd1};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 2'd1, 2'd0, 8'h00, 64'd2};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h00, 2'd2, 2'd0, 8'h00, 64'd3};
      vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'h07, 2'd2, 2'd0, 8'h00, 64'd3};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 2'd0, 8'h00, 64'd0};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 2'd1, 2'd0, 8'h00, 64'd0};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h2A, 2'd3, 2'd1, 8'h2A, 64'd1};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 2'd3, 2'd1, 8'h2A, 64'd1};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 2'd0, 8'h00, 64'd0};

      model_reset();
      repeat (3) step();
      chk("reset_hold.state", 64'(state), 64'd0);
      chk("reset_hold.cnt", cycle_cnt, 64'd0);
      rstn = 1;
      step();
      chk("after_reset.done", 64'(done), 64'd0);
      chk("after_reset.code", 64'(exit_code_q), 64'd0);

      for (int i = 0; i < 12; i++) begin
         clear = vecs[i].clr; start = vecs[i].st;
         exit_valid = vecs[i].ev; exit_code = vecs[i].code;
         step();
         clear = 0; start = 0; exit_valid = 0;
         $display("[TB] vec %0d: state=%0d cause=%0d code=%0h cnt=%0d",
                  i, state, fail_cause, exit_code_q, cycle_cnt);
         chk($sformatf("vec%0d.state", i), 64'(state), 64'(vecs[i].e_state));
         chk($sformatf("vec%0d.done", i), 64'(done), 64'(vecs[i].e_state[1]));
         chk($sformatf("vec%0d.cause", i), 64'(fail_cause), 64'(vecs[i].e_cause));
         chk($sformatf("vec%0d.code", i), 64'(exit_code_q), 64'(vecs[i].e_code));
         chk($sformatf("vec%0d.cnt", i), cycle_cnt, vecs[i].e_cnt);
      end

      // Cycle limit of 100: verdict one edge after the 100th run cycle.
      restart(64'd100, 24'd0, 4'b0000);
      run_until_verdict(200, n);
      $display("[TB] limit100: verdict after %0d cycles cause=%0d cnt=%0d", n, fail_cause, cycle_cnt);
      chk("limit.cycles", 64'(n), 64'd100);
      chk("limit.state", 64'(state), 64'd3);
      chk("limit.cause", 64'(fail_cause), 64'd2);
      chk("limit.cnt", cycle_cnt, 64'd100);

      restart(64'd0, 24'd0, 4'b0000);
      repeat (10000) step();
      $display("[TB] nolimit: state=%0d cnt=%0d", state, cycle_cnt);
      chk("nolimit.state", 64'(state), 64'd1);
      chk("nolimit.cnt", cycle_cnt, 64'd10000);

      // Channels 1 and 3 silent, 0 pulsed, 2 disabled.
      restart(64'd0, 24'd16, 4'b1011);
      n = 0;
      while (state == 2'd1 && n < 100) begin
         n++;
         heartbeat = (n % 10 == 0) ? 4'b0001 : 4'b0000;
         step();
         heartbeat = '0;
      end
      $display("[TB] hb1011: verdict after %0d cycles cause=%0d chan=%0d", n, fail_cause, fail_chan);
      chk("hb.cycles", 64'(n), 64'd16);
      chk("hb.cause", 64'(fail_cause), 64'd3);
      chk("hb.chan", 64'(fail_chan), 64'd1);

      // Channel 2 pulsed, channel 3 silent: only 3 may be reported.
      restart(64'd0, 24'd16, 4'b1100);
      n = 0;
      while (state == 2'd1 && n < 100) begin
         n++;
         heartbeat = (n % 5 == 0) ? 4'b0100 : 4'b0000;
         step();
         heartbeat = '0;
      end
      $display("[TB] hb1100: verdict after %0d cycles chan=%0d", n, fail_chan);
      chk("hb3.cycles", 64'(n), 64'd16);
      chk("hb3.chan", 64'(fail_chan), 64'd3);

      // Heartbeat on the exact expiry cycle cancels the timeout.
      restart(64'd0, 24'd16, 4'b0001);
      repeat (15) step();
      heartbeat = 4'b0001; step(); heartbeat = '0;
      $display("[TB] hb_cancel: state=%0d", state);
      chk("hb_cancel.state", 64'(state), 64'd1);
      repeat (15) step();
      chk("hb_rearm.still_run", 64'(state), 64'd1);
      step();
      chk("hb_rearm.state", 64'(state), 64'd3);
      chk("hb_rearm.chan", 64'(fail_chan), 64'd0);

      // Exit report coincides with the limit: exit wins.
      restart(64'd20, 24'd0, 4'b0000);
      repeat (19) step();
      chk("simul.pre_state", 64'(state), 64'd1);
      exit_valid = 1; exit_code = 8'h03; step(); exit_valid = 0;
      $display("[TB] simul: state=%0d cause=%0d code=%0h cnt=%0d", state, fail_cause, exit_code_q, cycle_cnt);
      chk("simul.cause", 64'(fail_cause), 64'd1);
      chk("simul.code", 64'(exit_code_q), 64'h03);
      chk("simul.cnt", cycle_cnt, 64'd20);

      // Limit below the current count never fires.
      restart(64'd0, 24'd0, 4'b0000);
      repeat (50) step();
      max_cycle = 64'd30;
      repeat (100) step();
      chk("late_limit.state", 64'(state), 64'd1);

      // Asynchronous reset at run cycle 37.
      restart(64'd0, 24'd0, 4'b0000);
      repeat (37) step();
      #2 rstn = 0;
      #1;
      $display("[TB] async_reset: state=%0d cnt=%0d", state, cycle_cnt);
      chk("areset.state", 64'(state), 64'd0);
      chk("areset.done", 64'(done), 64'd0);
      chk("areset.cnt", cycle_cnt, 64'd0);
      step(); step();
      rstn = 1;
      start = 1; step(); start = 0;
      chk("areset.restart_cnt", cycle_cnt, 64'd0);
      repeat (5) step();
      chk("areset.count5", cycle_cnt, 64'd5);

      // Randomized phase against the model.
      clear = 1; step(); clear = 0;
      for (int c = 0; c < 3000; c++) begin
         clear = (($urandom % 200) == 0) || (done && (($urandom % 20) == 0));
         start = ($urandom % 6) == 0;
         exit_valid = ($urandom % 60) == 0;
         exit_code = (($urandom % 3) == 0) ? 8'h00 : 8'($urandom);
         for (int i = 0; i < NCH; i++) heartbeat[i] = ($urandom % 6) == 0;
         if (($urandom % 80) == 0) hb_en = 4'($urandom);
         if (clear) begin
            max_cycle  = (($urandom % 2) == 0) ? 64'($urandom_range(5, 300)) : 64'd0;
            hb_timeout = (($urandom % 4) == 0) ? 24'd0 : 24'($urandom_range(3, 20));
         end
         step();
         if (c % 250 == 0)
            $display("[TB] rand %0d: state=%0d cause=%0d chan=%0d cnt=%0d",
                     c, state, fail_cause, fail_chan, cycle_cnt);
         chk_model($sformatf("rand%0d", c));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
